mmio_router: RTL and testbench
==============================

# mmio_router

Parametrised, registered memory-mapped I/O router between the CPU data port and the peripheral set (segment display, keyboard, timer, character memory, VGA, switches, LEDs). Decodes a configurable address field against a per-slave ID table and forwards one transaction at a time over a req/ack handshake. Collects read data and returns a single-cycle response to the CPU. Unmapped addresses and slaves that never acknowledge produce an error response and are counted in a saturating error counter.

## Interface
- `NSLV`, 8: number of slave ports.
- `ID_LO`, 20: low bit of the decoded address field.
- `ID_W`, 4: width of the decoded field; the field is `addr[ID_LO+ID_W-1:ID_LO]`.
- `SLV_ID`, {4'h2,4'h5,4'h3,4'h4,4'h8,4'h6,4'h7,4'hF}: packed `NSLV*ID_W` ID table; slave i uses bits `[i*ID_W +: ID_W]`, with slave 0 in the LSBs.
- `TIMEOUT`, 15: maximum number of WAIT cycles before an error response; 0 disables the timeout.
- `clk`  in  1  system clock; every element is rising-edge triggered.
- `rstn`  in  1  synchronous reset, active-low.
- `req`  in  1  CPU request valid; sampled only in IDLE.
- `we`  in  1  write enable (1 = write, 0 = read).
- `addr`  in  32  CPU address.
- `wdata`  in  32  write data.
- `wmask`  in  4  byte write mask.
- `ready`  out  1  one-cycle response strobe.
- `rdata`  out  32  read data; valid only while `ready`=1.
- `err`  out  1  error flag; valid only while `ready`=1.
- `err_cnt`  out  8  saturating count of error responses.
- `err_addr`  out  32  address of the most recent error response.
- `slv_sel`  out  NSLV  one-hot select of the target slave.
- `slv_req`  out  1  slave request; high throughout WAIT.
- `slv_we`, `slv_addr`, `slv_wdata`, `slv_wmask`  out  1/32/32/4  latched transaction fields, broadcast to all slaves.
- `slv_ack`  in  NSLV  per-slave acknowledge.
- `slv_rdata`  in  NSLV*32  per-slave read data; slave i uses bits `[i*32 +: 32]`.

## Operation
- Decode: slave i matches when the address field equals `SLV_ID[i]`. If several slaves match, the lowest index wins.
- The FSM has three states: IDLE, WAIT, RESP.
- IDLE, `req`=1, match:
  - latch `we`, `addr`, `wdata`, `wmask` and the one-hot select;
  - go to WAIT.
- IDLE, `req`=1, no match:
  - go to RESP with `err`=1 and `rdata`=0;
  - record `err_addr`=`addr`.
- IDLE, `req`=0: stay in IDLE.
- WAIT:
  - `slv_req`=1 and `slv_sel` is held.
  - On `slv_ack` of the selected slave, go to RESP with `err`=0 and `rdata` = that slave's `slv_rdata` for a read, 0 for a write.
  - Acks from non-selected slaves are ignored.
- WAIT timeout: when the wait counter reaches `TIMEOUT` without an ack, go to RESP with `err`=1, `rdata`=0 and `err_addr` = the latched address. An ack in the same cycle the counter reaches `TIMEOUT` takes priority and completes normally.
- RESP:
  - `ready`=1 for exactly one cycle, then return to IDLE.
  - `slv_sel` and `slv_req` are low.
- `err_cnt` increments on every RESP cycle with `err`=1 and saturates at 255.
- `req` is not sampled outside IDLE. The CPU holds `req` low, or ignores it, until it sees `ready`.
- The wait counter is `$clog2(TIMEOUT+1)` bits wide. It clears on entry to WAIT and increments once per WAIT cycle.
- Reset (`rstn`=0 at a clock edge), including mid-transaction:
  - state returns to IDLE;
  - `ready`, `err`, `rdata`, `slv_req`, `slv_sel`, `err_cnt`, `err_addr` and the wait counter go to 0;
  - the aborted transaction produces no response.

## Timing
- All outputs are registered except `slv_we`/`slv_addr`/`slv_wdata`/`slv_wmask`, which are driven directly from the latch registers.
- Mapped access, ack in the first WAIT cycle:
  - `req` sampled at edge 0;
  - `slv_req`=1 in cycle 1;
  - `ready`=1 in cycle 2.
  - Minimum latency is 2 cycles.
- Ack after k WAIT cycles: `ready` at cycle k+1.
- Unmapped access: `ready`=1 with `err`=1 in cycle 1.
- Timeout: `ready` with `err`=1 in cycle `TIMEOUT`+2 after the request edge.
- Back-to-back: a new `req` is accepted in the IDLE cycle following RESP, giving a throughput of 1 transaction per 3 cycles at best.

## Test plan
- Read from timer (`addr`=0x0030_0010, `slv_rdata[2]`=0x1234_5678, ack in the first WAIT cycle) -> `slv_sel`=8'b0000_0100 in cycle 1; `ready`=1, `rdata`=0x1234_5678, `err`=0 in cycle 2.
- Write to LED (`addr`=0x0070_0000, `wdata`=0xA5, `wmask`=4'b0001, ack after 3 cycles) -> `slv_we`=1, `slv_wdata`=0xA5 during WAIT; `ready` at cycle 4, `rdata`=0.
- Unmapped read (`addr`=0x0090_0000) -> `ready`=1, `err`=1 in cycle 1; `err_cnt`=1; `err_addr`=0x0090_0000; no `slv_req`.
- Selected slave never acks, `TIMEOUT`=15 -> `ready` with `err`=1 at cycle 17; wrong-slave acks during WAIT are ignored; `err_cnt` increments.
- 300 unmapped requests -> `err_cnt` saturates at 255.
- `rstn`=0 asserted in WAIT -> next cycle: IDLE, all outputs 0, no `ready`; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/mmio_router_if.sv
// CPU-side and peripheral-side bus bundle for the MMIO router.
// The router connects through the slave modport; the environment (CPU model
// plus peripherals) connects through the master modport.
interface mmio_router_if #(
    parameter int NSLV = 8
);
    // CPU request side
    logic               req;
    logic               we;
    logic [31:0]        addr;
    logic [31:0]        wdata;
    logic [3:0]         wmask;
    // CPU response side
    logic               ready;
    logic [31:0]        rdata;
    logic               err;
    logic [7:0]         err_cnt;
    logic [31:0]        err_addr;
    // Peripheral side
    logic [NSLV-1:0]    slv_sel;
    logic               slv_req;
    logic               slv_we;
    logic [31:0]        slv_addr;
    logic [31:0]        slv_wdata;
    logic [3:0]         slv_wmask;
    logic [NSLV-1:0]    slv_ack;
    logic [NSLV*32-1:0] slv_rdata;

    modport master (
        output req, we, addr, wdata, wmask, slv_ack, slv_rdata,
        input  ready, rdata, err, err_cnt, err_addr,
               slv_sel, slv_req, slv_we, slv_addr, slv_wdata, slv_wmask
    );

    modport slave (
        input  req, we, addr, wdata, wmask, slv_ack, slv_rdata,
        output ready, rdata, err, err_cnt, err_addr,
               slv_sel, slv_req, slv_we, slv_addr, slv_wdata, slv_wmask
    );
endinterface

// File: rtl/mmio_router.sv
// MMIO router: decodes an address field against a per-slave ID table, runs
// one transaction at a time over a req/ack handshake and returns a single
// cycle response. Unmapped addresses and slaves that never acknowledge give
// an error response, counted in a saturating counter.
module mmio_router #(
    parameter int                   NSLV    = 8,
    parameter int                   ID_LO   = 20,
    parameter int                   ID_W    = 4,
    // slave 0 sits in the LSBs: slave i -> ID listed i-th in {2,5,3,4,8,6,7,F}
    parameter logic [NSLV*ID_W-1:0] SLV_ID  = {4'hF, 4'h7, 4'h6, 4'h8,
                                               4'h4, 4'h3, 4'h5, 4'h2},
    parameter int                   TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rstn,
    mmio_router_if.slave bus
);

    // a zero TIMEOUT disables the timeout, but the counter still needs a bit
    localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;

    // control/response registers (reset)
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              slv_req_q, slv_req_d;
    logic [NSLV-1:0]   sel_q, sel_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [31:0]       err_addr_q, err_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // transaction latch (data only, not reset)
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wmask_q;
    logic              lat_en;

    // decode / selection helpers
    logic [ID_W-1:0]   field;
    logic              hit;
    logic [NSLV-1:0]   hit_sel;
    logic              ack_hit;
    logic [31:0]       sel_rdata;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign field   = bus.addr[ID_LO +: ID_W];
    assign ack_hit = |(bus.slv_ack & sel_q);

    // Address decode: first (lowest-index) matching slave wins.
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (!hit && field == SLV_ID[i*ID_W +: ID_W]) begin
                hit        = 1'b1;
                hit_sel[i] = 1'b1;
            end
        end
    end

    // One-hot read-data mux driven by the latched select.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | bus.slv_rdata[i*32 +: 32];
            end
        end
    end

    // Next-state and next-output logic of the IDLE/WAIT/RESP controller.
    always_comb begin
        state_d    = state_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        rdata_d    = '0;
        slv_req_d  = 1'b0;
        sel_d      = '0;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        cnt_d      = cnt_q;
        lat_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (hit) begin
                        state_d   = WAIT;
                        lat_en    = 1'b1;
                        slv_req_d = 1'b1;
                        sel_d     = hit_sel;
                        cnt_d     = '0;
                    end else begin
                        state_d    = RESP;
                        ready_d    = 1'b1;
                        err_d      = 1'b1;
                        err_addr_d = bus.addr;
                        err_cnt_d  = sat_inc(err_cnt_q);
                    end
                end
            end
            WAIT: begin
                slv_req_d = 1'b1;
                sel_d     = sel_q;
                // an ack on the last allowed cycle beats the timeout
                if (ack_hit) begin
                    state_d   = RESP;
                    ready_d   = 1'b1;
                    slv_req_d = 1'b0;
                    sel_d     = '0;
                    rdata_d   = we_q ? 32'd0 : sel_rdata;
                end else if (TIMEOUT != 0 && cnt_q == CNT_MAX) begin
                    state_d    = RESP;
                    ready_d    = 1'b1;
                    err_d      = 1'b1;
                    slv_req_d  = 1'b0;
                    sel_d      = '0;
                    err_addr_d = addr_q;
                    err_cnt_d  = sat_inc(err_cnt_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction silently.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            slv_req_q  <= 1'b0;
            sel_q      <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            slv_req_q  <= slv_req_d;
            sel_q      <= sel_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Capture the accepted transaction fields for broadcast to the slaves.
    always_ff @(posedge clk) begin
        if (lat_en) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            wmask_q <= bus.wmask;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.err_addr  = err_addr_q;
    assign bus.slv_req   = slv_req_q;
    assign bus.slv_sel   = sel_q;
    assign bus.slv_we    = we_q;
    assign bus.slv_addr  = addr_q;
    assign bus.slv_wdata = wdata_q;
    assign bus.slv_wmask = wmask_q;

endmodule

// File: tb/tb_mmio_router.sv
// Directed bench for mmio_router: a transaction-level model schedules the
// expected outputs of each cycle, a compare process checks them on every
// falling edge, and literal expectations pin latency and key values.
module tb_mmio_router;
    localparam int NSLV    = 8;
    localparam int TIMEOUT = 15;

    logic clk;
    logic rstn;
    mmio_router_if #(.NSLV(NSLV)) bus ();

    mmio_router #(
        .NSLV   (NSLV),
        .ID_LO  (20),
        .ID_W   (4),
        .SLV_ID (32'hF768_4352),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ID of slave i as listed in the peripheral map
    int id_tab [NSLV] = '{2, 5, 3, 4, 8, 6, 7, 15};
    int unmapped_ids [8] = '{0, 1, 9, 10, 11, 12, 13, 14};

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;
    int last_ready_cyc = -100;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    // expected per-cycle outputs, written by the transaction model
    logic            chk_en = 1'b0;
    logic            exp_ready = 1'b0, exp_err = 1'b0, exp_slv_req = 1'b0;
    logic            exp_fields = 1'b0, chk_static = 1'b0;
    logic [NSLV-1:0] exp_sel = '0;
    logic [31:0]     exp_rdata = '0, exp_addr = '0, exp_wdata = '0;
    logic            exp_we = 1'b0;
    logic [3:0]      exp_wmask = '0;
    logic [7:0]      m_err_cnt = '0;
    logic [31:0]     m_err_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NSLV; i++)
            if (int'(a[23:20]) == id_tab[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] sdata(input int i);
        if (i == 2) return 32'h1234_5678;
        return {16'hC0DE, 8'h00, 8'(i)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Record when and with what the DUT answered.
    always @(negedge clk) begin
        if (bus.ready) begin
            last_ready_cyc <= cyc;
            last_rdata     <= bus.rdata;
            last_err       <= bus.err;
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",   32'(bus.ready),   32'(exp_ready));
            check("slv_req", 32'(bus.slv_req), 32'(exp_slv_req));
            check("slv_sel", 32'(bus.slv_sel), 32'(exp_sel));
            if (exp_ready) begin
                check("err",   32'(bus.err), 32'(exp_err));
                check("rdata", bus.rdata,    exp_rdata);
            end
            if (exp_fields) begin
                check("slv_we",    32'(bus.slv_we),    32'(exp_we));
                check("slv_addr",  bus.slv_addr,       exp_addr);
                check("slv_wdata", bus.slv_wdata,      exp_wdata);
                check("slv_wmask", 32'(bus.slv_wmask), 32'(exp_wmask));
            end
            if (chk_static) begin
                check("err_cnt",  32'(bus.err_cnt), 32'(m_err_cnt));
                check("err_addr", bus.err_addr,     m_err_addr);
            end
        end
    end

    // One CPU transaction. k = WAIT cycle in which the target acks (0 = never);
    // noise = other slaves acking every WAIT cycle. Returns observed latency.
    task automatic run_txn(input logic t_we, input logic [31:0] t_addr,
                           input logic [31:0] t_wdata, input logic [3:0] t_wmask,
                           input int k, input logic [NSLV-1:0] noise, output int lat);
        int idx, n, c0;
        logic e;
        logic [31:0] rd;
        logic [NSLV-1:0] oh;
        idx = decode(t_addr);
        oh  = (idx >= 0) ? (NSLV'(1) << idx) : '0;
        if (idx < 0) begin
            n = 0; e = 1'b1;
        end else if (k >= 1 && k <= TIMEOUT + 1) begin
            n = k; e = 1'b0;
        end else begin
            n = TIMEOUT + 1; e = 1'b1;
        end
        rd = (e || t_we) ? 32'd0 : sdata(idx);
        bus.req = 1'b1; bus.we = t_we; bus.addr = t_addr;
        bus.wdata = t_wdata; bus.wmask = t_wmask;
        @(posedge clk); #2;
        c0 = cyc - 1;
        bus.req = 1'b0;
        bus.addr = ~t_addr;
        for (int j = 1; j <= n; j++) begin
            exp_slv_req = 1'b1; exp_sel = oh; exp_fields = 1'b1;
            exp_we = t_we; exp_addr = t_addr; exp_wdata = t_wdata; exp_wmask = t_wmask;
            bus.slv_ack = (j == k) ? oh : (noise & ~oh);
            @(posedge clk); #2;
        end
        bus.slv_ack = '0;
        exp_slv_req = 1'b0; exp_sel = '0; exp_fields = 1'b0;
        exp_ready = 1'b1; exp_err = e; exp_rdata = rd; chk_static = 1'b0;
        if (e) begin
            m_err_cnt  = (m_err_cnt == 8'd255) ? 8'd255 : m_err_cnt + 8'd1;
            m_err_addr = t_addr;
        end
        @(posedge clk); #2;
        exp_ready = 1'b0; chk_static = 1'b1;
        lat = last_ready_cyc - c0;
    endtask

    initial begin
        int lat;
        rstn = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wmask = '0;
        bus.slv_ack = '0;
        for (int i = 0; i < NSLV; i++) bus.slv_rdata[i*32 +: 32] = sdata(i);

        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b1;
        chk_en = 1'b1; chk_static = 1'b1;
        check("rst_ready",   32'(bus.ready),   32'd0);
        check("rst_slv_req", 32'(bus.slv_req), 32'd0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        check("rst_err_addr", bus.err_addr,    32'd0);
        @(posedge clk); #2;

        // timer read, ack in the first WAIT cycle
        run_txn(1'b0, 32'h0030_0010, 32'h0, 4'h0, 1, 8'h00, lat);
        check("timer_lat",   32'(lat), 32'd2);
        check("timer_rdata", last_rdata, 32'h1234_5678);
        check("timer_err",   32'(last_err), 32'd0);

        // LED write, ack after 3 WAIT cycles
        run_txn(1'b1, 32'h0070_0000, 32'h0000_00A5, 4'b0001, 3, 8'h00, lat);
        check("led_lat",   32'(lat), 32'd4);
        check("led_rdata", last_rdata, 32'd0);

        // unmapped read
        run_txn(1'b0, 32'h0090_0000, 32'h0, 4'h0, 0, 8'h00, lat);
        check("unmap_lat",      32'(lat), 32'd1);
        check("unmap_err",      32'(last_err), 32'd1);
        check("unmap_err_cnt",  32'(bus.err_cnt), 32'd1);
        check("unmap_err_addr", bus.err_addr, 32'h0090_0000);

        // selected slave never acks while every other slave does
        run_txn(1'b0, 32'h0080_0004, 32'h0, 4'h0, 0, 8'hFF, lat);
        check("tmo_lat",      32'(lat), 32'(TIMEOUT + 2));
        check("tmo_err",      32'(last_err), 32'd1);
        check("tmo_err_cnt",  32'(bus.err_cnt), 32'd2);
        check("tmo_err_addr", bus.err_addr, 32'h0080_0004);

        // ack in the very cycle the counter reaches TIMEOUT completes normally
        run_txn(1'b0, 32'h00F0_0000, 32'h0, 4'h0, TIMEOUT + 1, 8'h00, lat);
        check("edge_lat",   32'(lat), 32'd17);
        check("edge_err",   32'(last_err), 32'd0);
        check("edge_rdata", last_rdata, 32'hC0DE_0007);

        // reset asserted in the middle of WAIT
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h0050_0000;
        bus.wdata = 32'h0; bus.wmask = 4'h0;
        @(posedge clk); #2;
        bus.req = 1'b0;
        exp_slv_req = 1'b1; exp_sel = 8'b0000_0010; exp_fields = 1'b1;
        exp_we = 1'b0; exp_addr = 32'h0050_0000; exp_wdata = 32'h0; exp_wmask = 4'h0;
        @(posedge clk); #2;
        rstn = 1'b0;
        @(posedge clk); #2;
        rstn = 1'b1;
        exp_slv_req = 1'b0; exp_sel = '0; exp_fields = 1'b0;
        m_err_cnt = '0; m_err_addr = '0;
        check("mrst_ready",    32'(bus.ready),   32'd0);
        check("mrst_err",      32'(bus.err),     32'd0);
        check("mrst_rdata",    bus.rdata,        32'd0);
        check("mrst_slv_sel",  32'(bus.slv_sel), 32'd0);
        check("mrst_err_cnt",  32'(bus.err_cnt), 32'd0);
        repeat (3) begin
            @(posedge clk); #2;
        end
        run_txn(1'b0, 32'h0020_0000, 32'h0, 4'h0, 2, 8'h10, lat);
        check("post_rst_lat",   32'(lat), 32'd3);
        check("post_rst_rdata", last_rdata, 32'hC0DE_0000);

        // error counter saturation
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = {8'($urandom), 4'(unmapped_ids[i % 8]), 20'($urandom)};
            run_txn(1'b0, a, 32'h0, 4'h0, 0, 8'h00, lat);
        end
        check("sat_err_cnt", 32'(bus.err_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
